// File: rtl/calc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// calc_seq_ctrl
// Sequencing controller for a one-digit add/subtract calculator.
// It debounces the push switches, runs the entry state machine, and holds the
// operands, the operator and the result. It also generates the display value.
//
// Ports
//   CLK        : system clock, rising edge
//   RST        : asynchronous active-high reset
//   PSW[13:0]  : raw push switches (9..0 digits, 10 ADD, 11 SUB, 12 EQ, 13 CLR)
//   SUM_DATA   : A_DATA + B_DATA from the external adder
//   SUB_DATA   : A_DATA - B_DATA from the external subtractor (two's complement)
//   A_DATA     : registered operand A
//   B_DATA     : registered operand B
//   OP_SUB     : registered operator (0 add, 1 subtract)
//   RESULT     : result latched on EQ
//   DISP_DATA  : registered display value
//   DISP_BLANK : registered display-off flag
//   STATE      : current FSM state encoding
// -----------------------------------------------------------------------------
module calc_seq_ctrl #(
  parameter int DB_TICK = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [13:0] PSW,
  input  logic [5:0]  SUM_DATA,
  input  logic [5:0]  SUB_DATA,
  output logic [3:0]  A_DATA,
  output logic [3:0]  B_DATA,
  output logic        OP_SUB,
  output logic [5:0]  RESULT,
  output logic [5:0]  DISP_DATA,
  output logic        DISP_BLANK,
  output logic [2:0]  STATE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GOT_A  = 3'd1,
    S_GOT_OP = 3'd2,
    S_GOT_B  = 3'd3,
    S_SHOW   = 3'd4
  } state_t;

  localparam int CW = $clog2(DB_TICK);
  localparam logic [CW-1:0] PRESC_LAST = CW'(DB_TICK - 1);

  logic [13:0]   r_sync1, r_sync2, r_samp, r_deb, r_deb_q;
  logic [CW-1:0] r_presc;
  logic          w_tick;
  logic [13:0]   w_agree, w_deb_nxt, w_evt;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_a, r_b, w_a_nxt, w_b_nxt;
  logic        r_op_sub, w_op_nxt;
  logic [5:0]  r_result, w_result_nxt;
  logic [5:0]  r_disp_data, w_disp_data_nxt;
  logic        r_disp_blank, w_disp_blank_nxt;

  logic        w_clr, w_eq, w_add, w_sub, w_dig;
  logic [3:0]  w_dig_val;

  assign w_tick    = (r_presc == PRESC_LAST);
  // A bit's debounced value only moves when two consecutive samples agree.
  assign w_agree   = ~(r_sync2 ^ r_samp);
  assign w_deb_nxt = (r_sync2 & w_agree) | (r_deb & ~w_agree);
  assign w_evt     = r_deb & ~r_deb_q;

  // Synchronizer, prescaler and debounce registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 14'd0;
      r_sync2 <= 14'd0;
      r_samp  <= 14'd0;
      r_deb   <= 14'd0;
      r_deb_q <= 14'd0;
      r_presc <= '0;
    end else begin
      r_sync1 <= PSW;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_samp <= r_sync2;
        r_deb  <= w_deb_nxt;
      end else begin
        r_samp <= r_samp;
        r_deb  <= r_deb;
      end
    end
  end

  // Event arbitration: CLR > EQ > ADD > SUB > lowest digit
  always_comb begin
    w_clr     = w_evt[13];
    w_eq      = w_evt[12] & ~w_evt[13];
    w_add     = w_evt[10] & ~w_evt[12] & ~w_evt[13];
    w_sub     = w_evt[11] & ~w_evt[10] & ~w_evt[12] & ~w_evt[13];
    w_dig     = (|w_evt[9:0]) & ~(|w_evt[13:10]);
    w_dig_val = 4'd0;
    // Scan downward so the lowest pressed digit is assigned last and wins.
    for (int i = 9; i >= 0; i--) begin
      if (w_evt[i]) begin
        w_dig_val = 4'(i);
      end else begin
        w_dig_val = w_dig_val;
      end
    end
  end

  // Next-state, datapath register and display computation
  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_op_nxt     = r_op_sub;
    w_result_nxt = r_result;
    if (w_clr) begin
      w_state_nxt  = S_IDLE;
      w_a_nxt      = 4'd0;
      w_b_nxt      = 4'd0;
      w_op_nxt     = 1'b0;
      w_result_nxt = 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dig) begin
            w_a_nxt     = w_dig_val;
            w_state_nxt = S_GOT_A;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_GOT_A: begin
          if (w_dig) begin
            w_a_nxt = w_dig_val;
          end else if (w_add || w_sub) begin
            w_op_nxt    = w_sub;
            w_state_nxt = S_GOT_OP;
          end else begin
            w_state_nxt = S_GOT_A;
          end
        end
        S_GOT_OP: begin
          if (w_dig) begin
            w_b_nxt     = w_dig_val;
            w_state_nxt = S_GOT_B;
          end else if (w_add || w_sub) begin
            w_op_nxt = w_sub;
          end else begin
            w_state_nxt = S_GOT_OP;
          end
        end
        S_GOT_B: begin
          if (w_dig) begin
            w_b_nxt = w_dig_val;
          end else if (w_add || w_sub) begin
            w_op_nxt = w_sub;
          end else if (w_eq) begin
            // Operands have been stable for at least a cycle, so the
            // external arithmetic outputs are settled here.
            w_result_nxt = r_op_sub ? SUB_DATA : SUM_DATA;
            w_state_nxt  = S_SHOW;
          end else begin
            w_state_nxt = S_GOT_B;
          end
        end
        S_SHOW: begin
          if (w_dig) begin
            w_a_nxt     = w_dig_val;
            w_b_nxt     = 4'd0;
            w_state_nxt = S_GOT_A;
          end else begin
            w_state_nxt = S_SHOW;
          end
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_a_nxt      = 4'd0;
          w_b_nxt      = 4'd0;
          w_op_nxt     = 1'b0;
          w_result_nxt = 6'd0;
        end
      endcase
    end

    // Display is derived from next values so it tracks the registers exactly.
    w_disp_blank_nxt = 1'b0;
    w_disp_data_nxt  = 6'd0;
    case (w_state_nxt)
      S_IDLE: begin
        w_disp_blank_nxt = 1'b1;
        w_disp_data_nxt  = 6'd0;
      end
      S_GOT_A, S_GOT_OP: w_disp_data_nxt = {2'b00, w_a_nxt};
      S_GOT_B:           w_disp_data_nxt = {2'b00, w_b_nxt};
      S_SHOW:            w_disp_data_nxt = w_result_nxt;
      default: begin
        w_disp_blank_nxt = 1'b1;
        w_disp_data_nxt  = 6'd0;
      end
    endcase
  end

  // State, datapath and display registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_a          <= 4'd0;
      r_b          <= 4'd0;
      r_op_sub     <= 1'b0;
      r_result     <= 6'd0;
      r_disp_data  <= 6'd0;
      r_disp_blank <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_a          <= w_a_nxt;
      r_b          <= w_b_nxt;
      r_op_sub     <= w_op_nxt;
      r_result     <= w_result_nxt;
      r_disp_data  <= w_disp_data_nxt;
      r_disp_blank <= w_disp_blank_nxt;
    end
  end

  assign A_DATA     = r_a;
  assign B_DATA     = r_b;
  assign OP_SUB     = r_op_sub;
  assign RESULT     = r_result;
  assign DISP_DATA  = r_disp_data;
  assign DISP_BLANK = r_disp_blank;
  assign STATE      = r_state;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_calc_seq_ctrl
// Directed self-checking bench for calc_seq_ctrl with DB_TICK = 4.
// The adder and subtractor are modelled here as the environment.
// -----------------------------------------------------------------------------
module tb_calc_seq_ctrl;

  localparam int DBT = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [13:0] PSW = 14'd0;
  logic [5:0]  SUM_DATA, SUB_DATA;
  logic [3:0]  A_DATA, B_DATA;
  logic        OP_SUB;
  logic [5:0]  RESULT, DISP_DATA;
  logic        DISP_BLANK;
  logic [2:0]  STATE;

  int errors = 0;
  int checks = 0;

  localparam logic [13:0] K_ADD = 14'h0400;
  localparam logic [13:0] K_SUB = 14'h0800;
  localparam logic [13:0] K_EQ  = 14'h1000;
  localparam logic [13:0] K_CLR = 14'h2000;

  calc_seq_ctrl #(.DB_TICK(DBT)) dut (
    .CLK(CLK), .RST(RST), .PSW(PSW),
    .SUM_DATA(SUM_DATA), .SUB_DATA(SUB_DATA),
    .A_DATA(A_DATA), .B_DATA(B_DATA), .OP_SUB(OP_SUB),
    .RESULT(RESULT), .DISP_DATA(DISP_DATA), .DISP_BLANK(DISP_BLANK),
    .STATE(STATE)
  );

  assign SUM_DATA = {2'b00, A_DATA} + {2'b00, B_DATA};
  assign SUB_DATA = {2'b00, A_DATA} - {2'b00, B_DATA};

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  // Hold a key pattern well past the worst-case latency, then release it long enough
  task automatic press(input logic [13:0] keys);
    @(negedge CLK);
    PSW = keys;
    cycles(20);
    PSW = 14'd0;
    cycles(20);
  endtask

  function automatic logic [13:0] dig(input int d);
    logic [13:0] v;
    v = 14'd1 << d;
    return v;
  endfunction

  initial begin
    int n;
    // Reset state
    cycles(3);
    check("rst_state", {5'd0, STATE}, 8'd0);
    check("rst_blank", {7'd0, DISP_BLANK}, 8'd1);
    RST = 1'b0;
    cycles(2);
    check("idle_state", {5'd0, STATE}, 8'd0);
    check("idle_a", {4'd0, A_DATA}, 8'd0);
    check("idle_b", {4'd0, B_DATA}, 8'd0);
    check("idle_op", {7'd0, OP_SUB}, 8'd0);
    check("idle_res", {2'd0, RESULT}, 8'd0);
    check("idle_disp", {2'd0, DISP_DATA}, 8'd0);
    check("idle_blank", {7'd0, DISP_BLANK}, 8'd1);

    // EQ ignored in IDLE
    press(K_EQ);
    check("eq_idle_state", {5'd0, STATE}, 8'd0);
    check("eq_idle_res", {2'd0, RESULT}, 8'd0);

    // 7 + 5 =
    press(dig(7));
    check("a7_state", {5'd0, STATE}, 8'd1);
    check("a7_a", {4'd0, A_DATA}, 8'd7);
    check("a7_disp", {2'd0, DISP_DATA}, 8'd7);
    check("a7_blank", {7'd0, DISP_BLANK}, 8'd0);
    press(K_EQ);
    check("eq_gota_state", {5'd0, STATE}, 8'd1);
    press(K_ADD);
    check("add_state", {5'd0, STATE}, 8'd2);
    check("add_op", {7'd0, OP_SUB}, 8'd0);
    press(K_EQ);
    check("eq_gotop_state", {5'd0, STATE}, 8'd2);
    check("eq_gotop_res", {2'd0, RESULT}, 8'd0);
    press(dig(5));
    check("b5_state", {5'd0, STATE}, 8'd3);
    check("b5_b", {4'd0, B_DATA}, 8'd5);
    check("b5_disp", {2'd0, DISP_DATA}, 8'd5);
    // EQ: watch for the state change and check result and display together
    @(negedge CLK);
    PSW = K_EQ;
    n = 0;
    while (STATE != 3'd4 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("eq_seen", {7'd0, (n < 40)}, 8'd1);
    check("sum_res", {2'd0, RESULT}, 8'd12);
    check("sum_disp", {2'd0, DISP_DATA}, 8'd12);
    cycles(20);
    PSW = 14'd0;
    cycles(20);
    check("sum_state", {5'd0, STATE}, 8'd4);
    check("sum_blank", {7'd0, DISP_BLANK}, 8'd0);
    check("sum_a", {4'd0, A_DATA}, 8'd7);

    // 3 - 9 = -6
    press(dig(3));
    check("new_a3", {4'd0, A_DATA}, 8'd3);
    check("new_b0", {4'd0, B_DATA}, 8'd0);
    check("new_state", {5'd0, STATE}, 8'd1);
    press(K_SUB);
    check("sub_op", {7'd0, OP_SUB}, 8'd1);
    press(dig(9));
    check("b9", {4'd0, B_DATA}, 8'd9);
    press(K_EQ);
    check("diff_res", {2'd0, RESULT}, 8'b0011_1010);
    check("diff_disp", {2'd0, DISP_DATA}, 8'b0011_1010);
    check("diff_op", {7'd0, OP_SUB}, 8'd1);
    // EQ held in SHOW changes nothing
    press(K_EQ);
    check("show_eq_res", {2'd0, RESULT}, 8'b0011_1010);

    // 2 + 2 =
    press(dig(2));
    check("a2_b_cleared", {4'd0, B_DATA}, 8'd0);
    check("a2", {4'd0, A_DATA}, 8'd2);
    press(K_ADD);
    press(dig(2));
    press(K_EQ);
    check("sum4_res", {2'd0, RESULT}, 8'd4);
    check("sum4_state", {5'd0, STATE}, 8'd4);

    // Priority: EQ + CLR in GOT_B
    press(dig(1));
    press(K_SUB);
    press(dig(8));
    check("pri_pre_state", {5'd0, STATE}, 8'd3);
    press(K_EQ | K_CLR);
    check("pri_state", {5'd0, STATE}, 8'd0);
    check("pri_a", {4'd0, A_DATA}, 8'd0);
    check("pri_b", {4'd0, B_DATA}, 8'd0);
    check("pri_op", {7'd0, OP_SUB}, 8'd0);
    check("pri_res", {2'd0, RESULT}, 8'd0);
    check("pri_disp", {2'd0, DISP_DATA}, 8'd0);
    check("pri_blank", {7'd0, DISP_BLANK}, 8'd1);

    // Digits 4 and 6 together: lowest wins
    press(dig(4) | dig(6));
    check("dig46_a", {4'd0, A_DATA}, 8'd4);
    check("dig46_state", {5'd0, STATE}, 8'd1);
    press(K_CLR);
    check("clr_state", {5'd0, STATE}, 8'd0);

    // Glitches on PSW[5]: one cycle high every 3 cycles for 40 cycles
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      PSW = (i % 3 == 0) ? dig(5) : 14'd0;
    end
    @(negedge CLK);
    PSW = 14'd0;
    cycles(20);
    check("glitch_state", {5'd0, STATE}, 8'd0);
    check("glitch_a", {4'd0, A_DATA}, 8'd0);
    press(dig(5));
    check("clean5_a", {4'd0, A_DATA}, 8'd5);
    check("clean5_state", {5'd0, STATE}, 8'd1);

    // ADD then SUB in GOT_OP
    press(K_ADD);
    check("op_add", {7'd0, OP_SUB}, 8'd0);
    press(K_SUB);
    check("op_sub", {7'd0, OP_SUB}, 8'd1);
    check("op_state", {5'd0, STATE}, 8'd2);

    // Async reset mid-press in GOT_OP
    @(negedge CLK);
    PSW = dig(3);
    cycles(5);
    #2 RST = 1'b1;
    #1;
    check("async_state", {5'd0, STATE}, 8'd0);
    check("async_a", {4'd0, A_DATA}, 8'd0);
    check("async_op", {7'd0, OP_SUB}, 8'd0);
    check("async_blank", {7'd0, DISP_BLANK}, 8'd1);
    cycles(2);
    RST = 1'b0;
    cycles(25);
    check("held_state", {5'd0, STATE}, 8'd1);
    check("held_a", {4'd0, A_DATA}, 8'd3);
    PSW = 14'd0;
    cycles(20);
    check("held_once", {5'd0, STATE}, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
# calc_seq_ctrl

Sequencing controller for the one-digit add/subtract calculator datapath. It debounces the 14 push switches, runs the operand/operator entry state machine, and drives the 4-bit operand buses into the combinational adder and subtractor. It latches the selected 6-bit result on "=" and presents a display value and blank flag to the 7-segment driver.

## Interface
Parameters:
- DB_TICK, 50000: debounce sample period in CLK cycles (≥2); benches use 4.

Ports:
- CLK  in  1  system clock; all flops rising-edge.
- RST  in  1  reset, asynchronous, active-high.
- PSW  in  14  raw push switches, 1 = pressed, asynchronous to CLK. Bits 9..0 are digits 9..0; 10 ADD; 11 SUB; 12 EQ; 13 CLR.
- SUM_DATA  in  6  A_DATA+B_DATA from adder, unsigned.
- SUB_DATA  in  6  A_DATA−B_DATA from subtractor, two's complement.
- A_DATA  out  4  registered operand A.
- B_DATA  out  4  registered operand B.
- OP_SUB  out  1  registered operator: 0 add, 1 subtract.
- RESULT  out  6  latched result.
- DISP_DATA  out  6  value to display; two's complement when OP_SUB=1 in SHOW, else unsigned.
- DISP_BLANK  out  1  1 = display off.
- STATE  out  3  current FSM state encoding.

## Operation
- Input path, per bit:
  - 2-FF synchronizer.
  - Shared prescaler asserts a one-cycle tick every DB_TICK cycles.
  - On a tick: samp <= sync. If sync == samp, deb <= sync.
  - Press event = deb & ~deb_q, a one-cycle pulse per press. Release generates nothing.
- Event arbitration: events in the same cycle resolve as CLR > EQ > ADD > SUB > lowest digit. Losing events are discarded.
- FSM encoding: IDLE=0, GOT_A=1, GOT_OP=2, GOT_B=3, SHOW=4.
- FSM transitions:
  - IDLE: digit d -> A_DATA=d, GOT_A. Ops and EQ are ignored.
  - GOT_A: digit replaces A_DATA and stays. ADD/SUB sets OP_SUB and goes to GOT_OP. EQ is ignored.
  - GOT_OP: digit -> B_DATA=d, GOT_B. ADD/SUB overwrites OP_SUB and stays. EQ is ignored.
  - GOT_B: digit replaces B_DATA. ADD/SUB overwrites OP_SUB. EQ -> RESULT = OP_SUB ? SUB_DATA : SUM_DATA, then SHOW.
  - SHOW: digit d starts a new calculation: A_DATA=d, B_DATA=0, GOT_A. ADD/SUB/EQ are ignored; RESULT is held.
  - Any state: CLR -> IDLE and clears A_DATA, B_DATA, OP_SUB and RESULT.
- Display:
  - IDLE: DISP_BLANK=1, DISP_DATA=0.
  - GOT_A and GOT_OP: DISP_DATA = {2'b00, A_DATA}.
  - GOT_B: DISP_DATA = {2'b00, B_DATA}.
  - SHOW: DISP_DATA = RESULT.
  - DISP_BLANK=0 in every state except IDLE.
- Arithmetic: digits are 0..9. The sum range is 0..18 and the difference range is −9..+9, so neither overflows 6 bits. No range checking is done here.
- Output registers: all outputs come from flops, including DISP_DATA, DISP_BLANK and STATE.

## Timing
- Reset values: STATE=0, A_DATA=0, B_DATA=0, OP_SUB=0, RESULT=0, DISP_DATA=0, DISP_BLANK=1. The prescaler, samp, deb and deb_q are all cleared.
- Reset mid-entry aborts immediately to IDLE. A key held through reset release produces one event after debounce.
- Press latency: PSW high -> 2 cycles to sync -> up to 2·DB_TICK to deb -> event the next cycle -> register update the cycle after. Worst case is 2·DB_TICK+4 cycles.
- A press must be held at least 2·DB_TICK+4 cycles to register. Bounces shorter than DB_TICK never produce an event.
- EQ to RESULT valid: 1 cycle after the event. DISP_DATA shows the result in that same cycle.
- Datapath timing: A_DATA, B_DATA and OP_SUB are stable for at least 1 cycle before any EQ can be accepted.
- Holding a key yields exactly one event. Re-pressing requires release for at least 2·DB_TICK cycles.

## Test plan
- Sequence 7, ADD, 5, EQ (DB_TICK=4): A=7, B=5, OP_SUB=0. RESULT=DISP_DATA=6'd12, STATE=4, DISP_BLANK=0.
- Sequence 3, SUB, 9, EQ: RESULT=6'b111010 (−6), OP_SUB=1. Then 2, ADD, 2, EQ gives RESULT=4, with B cleared to 0 on the entry of 2.
- Priority: EQ+CLR pressed together in GOT_B -> IDLE with all outputs at reset values. Digits 4 and 6 together in IDLE -> A=4.
- Debounce: 1-cycle glitches on PSW[5] every 3 cycles for 40 cycles -> no state change. A clean 20-cycle hold -> exactly one event, A=5.
- Ignored events: EQ in IDLE, GOT_A and GOT_OP leaves state and RESULT unchanged. ADD then SUB in GOT_OP -> OP_SUB=1 and the state stays GOT_OP.
- Async RST asserted mid-press in GOT_OP: outputs reset within the same cycle, not waiting for a clock edge. The key held across release -> one event after debounce, and the state moves to GOT_A for a digit key.
